// File: rtl/bumpy_pkg.sv
// Shared definitions for the smiley/brick game blocks: edge bit indices,
// the hit-edge code type and the collision FSM state encoding.
package bumpy_pkg;

  localparam int EDGE_BOTTOM = 0;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_LEFT   = 3;

  typedef logic [3:0] hit_edge_t;

  typedef enum logic {
    ST_SCAN   = 1'b0,
    ST_REPORT = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/edge_classifier.sv
// Combinational edge classification of a sprite-relative pixel offset.
// Offsets outside the sprite box produce an empty code.
module edge_classifier
  import bumpy_pkg::*;
#(
  parameter int OBJECT_WIDTH  = 32,
  parameter int OBJECT_HEIGHT = 32,
  parameter int EDGE_DEPTH    = 4
) (
  input  logic signed [11:0] offX,
  input  logic signed [11:0] offY,
  output hit_edge_t          code
);

  localparam logic signed [11:0] WIDTH_S  = 12'(OBJECT_WIDTH);
  localparam logic signed [11:0] HEIGHT_S = 12'(OBJECT_HEIGHT);
  localparam logic signed [11:0] DEPTH_S  = 12'(EDGE_DEPTH);
  localparam logic signed [11:0] RIGHT_S  = 12'(OBJECT_WIDTH - EDGE_DEPTH);
  localparam logic signed [11:0] BOTTOM_S = 12'(OBJECT_HEIGHT - EDGE_DEPTH);

  logic in_box_s;

  // Edge bands are independent, so corners set two bits at once.
  always_comb begin
    code     = 4'b0000;
    in_box_s = (offX >= 12'sd0) && (offX < WIDTH_S) &&
               (offY >= 12'sd0) && (offY < HEIGHT_S);
    if (in_box_s) begin
      code[EDGE_TOP]    = (offY < DEPTH_S);
      code[EDGE_BOTTOM] = (offY >= BOTTOM_S);
      code[EDGE_LEFT]   = (offX < DEPTH_S);
      code[EDGE_RIGHT]  = (offX >= RIGHT_S);
    end else begin
      code = 4'b0000;
    end
  end

endmodule

// File: rtl/smiley_collision_detector.sv
// Smiley/brick collision detector: accumulates per-frame edge hits from a
// two-register pixel pipeline and reports them in the cycle after startOfFrame.
module smiley_collision_detector
  import bumpy_pkg::*;
#(
  parameter int OBJECT_WIDTH  = 32,
  parameter int OBJECT_HEIGHT = 32,
  parameter int EDGE_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic               smileyDrawingRequest,
  input  logic               brickDrawingRequest,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  output logic               collision,
  output logic [3:0]         HitEdgeCode,
  output logic [7:0]         hitCount
);

  logic               overlap_q;
  logic signed [11:0] off_x_q, off_y_q;
  logic signed [11:0] off_x_d, off_y_d;
  hit_edge_t          code_s, contrib_s;
  hit_edge_t          acc_q, edge_code_q;
  logic               hit_seen_q, sof_pend_q, collision_q, sof_s;
  logic [7:0]         hit_count_q;
  fsm_state_e         state_q;

  assign off_x_d = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
  assign off_y_d = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});

  // Stage 1: overlap flag and sprite-relative offsets.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      overlap_q <= 1'b0;
      off_x_q   <= 12'sd0;
      off_y_q   <= 12'sd0;
    end else begin
      overlap_q <= smileyDrawingRequest & brickDrawingRequest;
      off_x_q   <= off_x_d;
      off_y_q   <= off_y_d;
    end
  end

  edge_classifier #(
    .OBJECT_WIDTH  (OBJECT_WIDTH),
    .OBJECT_HEIGHT (OBJECT_HEIGHT),
    .EDGE_DEPTH    (EDGE_DEPTH)
  ) u_classifier (
    .offX (off_x_q),
    .offY (off_y_q),
    .code (code_s)
  );

  assign contrib_s = overlap_q ? code_s : 4'b0000;
  // A frame start seen during REPORT is replayed on the following SCAN cycle.
  assign sof_s     = startOfFrame | sof_pend_q;

  // Frame FSM; the report is taken at the frame-start edge so the pixel
  // arriving in the same edge already belongs to the new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_SCAN;
      acc_q       <= 4'b0000;
      hit_seen_q  <= 1'b0;
      sof_pend_q  <= 1'b0;
      collision_q <= 1'b0;
      edge_code_q <= 4'b0000;
      hit_count_q <= 8'd0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          sof_pend_q <= 1'b0;
          if (sof_s && hit_seen_q) begin
            state_q     <= ST_REPORT;
            collision_q <= 1'b1;
            edge_code_q <= acc_q;
            acc_q       <= contrib_s;
            hit_seen_q  <= overlap_q;
            if (hit_count_q != 8'hFF) begin
              hit_count_q <= hit_count_q + 8'd1;
            end
          end else begin
            collision_q <= 1'b0;
            if (sof_s) begin
              edge_code_q <= 4'b0000;
            end
            acc_q      <= acc_q | contrib_s;
            hit_seen_q <= hit_seen_q | overlap_q;
          end
        end
        ST_REPORT: begin
          state_q     <= ST_SCAN;
          collision_q <= 1'b0;
          sof_pend_q  <= startOfFrame;
          acc_q       <= acc_q | contrib_s;
          hit_seen_q  <= hit_seen_q | overlap_q;
        end
        default: begin
          state_q     <= ST_SCAN;
          collision_q <= 1'b0;
          sof_pend_q  <= 1'b0;
          acc_q       <= 4'b0000;
          hit_seen_q  <= 1'b0;
        end
      endcase
    end
  end

  assign collision   = collision_q;
  assign HitEdgeCode = edge_code_q;
  assign hitCount    = hit_count_q;

endmodule

// File: tb/tb_smiley_collision_detector.sv
// Directed vector table, saturation/reset sequences and a randomized run
// against a frame-window reference model.
module tb_smiley_collision_detector;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic [10:0]        pixelX, pixelY;
  logic               smileyDrawingRequest, brickDrawingRequest;
  logic signed [10:0] topLeftX, topLeftY;
  logic               collision;
  logic [3:0]         HitEdgeCode;
  logic [7:0]         hitCount;

  int vectors = 0;
  int miscompares = 0;

  smiley_collision_detector dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (startOfFrame),
    .pixelX               (pixelX),
    .pixelY               (pixelY),
    .smileyDrawingRequest (smileyDrawingRequest),
    .brickDrawingRequest  (brickDrawingRequest),
    .topLeftX             (topLeftX),
    .topLeftY             (topLeftY),
    .collision            (collision),
    .HitEdgeCode          (HitEdgeCode),
    .hitCount             (hitCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sof;
    logic       sm;
    logic       br;
    int         px;
    int         py;
    int         tlx;
    int         tly;
    logic       ec;
    logic [3:0] eh;
    logic [7:0] en;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } ev_t;

  vec_t tbl[$];
  ev_t  evq[$];

  logic       m_coll, m_pend;
  logic [3:0] m_code;
  int         m_cnt;
  int         cyc;

  function automatic vec_t v(logic sof, logic sm, logic br, int px, int py, int tlx, int tly,
                             logic ec, logic [3:0] eh, logic [7:0] en);
    vec_t r;
    r.sof = sof; r.sm = sm; r.br = br; r.px = px; r.py = py; r.tlx = tlx; r.tly = tly;
    r.ec = ec; r.eh = eh; r.en = en;
    return r;
  endfunction

  // Sprite box is 32x32 with 4-pixel edge bands.
  function automatic logic [3:0] model_code(int ox, int oy);
    logic [3:0] c;
    c = 4'b0000;
    if (ox >= 0 && ox < 32 && oy >= 0 && oy < 32) begin
      if (oy < 4)   c[2] = 1'b1;
      if (oy >= 28) c[0] = 1'b1;
      if (ox < 4)   c[3] = 1'b1;
      if (ox >= 28) c[1] = 1'b1;
    end
    return c;
  endfunction

  task automatic drive(logic sof, logic sm, logic br, int px, int py, int tlx, int tly);
    startOfFrame = sof;
    smileyDrawingRequest = sm;
    brickDrawingRequest = br;
    pixelX = 11'(px);
    pixelY = 11'(py);
    topLeftX = 11'(tlx);
    topLeftY = 11'(tly);
  endtask

  task automatic step(logic sof, logic sm, logic br, int px, int py, int tlx, int tly);
    drive(sof, sm, br, px, py, tlx, tly);
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic ec, logic [3:0] eh, logic [7:0] en);
    vectors++;
    if (collision !== ec || HitEdgeCode !== eh || hitCount !== en) begin
      miscompares++;
      $display("FAIL %s: got collision=%b HitEdgeCode=%b hitCount=%0d, want collision=%b HitEdgeCode=%b hitCount=%0d",
               name, collision, HitEdgeCode, hitCount, ec, eh, en);
    end
  endtask

  // Reference: a frame start at edge k (deferred one edge if it lands in a
  // report cycle) reports every overlap presented at edges <= k-2 not yet reported.
  task automatic model_edge(logic sof, logic ovl, int ox, int oy);
    logic eff, any, new_coll;
    logic [3:0] acc;
    eff = (sof && !m_coll) || m_pend;
    m_pend = sof && m_coll;
    new_coll = 1'b0;
    if (eff) begin
      any = 1'b0;
      acc = 4'b0000;
      while (evq.size() > 0 && evq[0].cyc <= cyc - 2) begin
        any = 1'b1;
        acc = acc | evq[0].code;
        void'(evq.pop_front());
      end
      if (any) begin
        new_coll = 1'b1;
        m_code = acc;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_code = 4'b0000;
      end
    end
    m_coll = new_coll;
    if (ovl) begin
      ev_t e;
      e.cyc = cyc;
      e.code = model_code(ox, oy);
      evq.push_back(e);
    end
  endtask

  initial begin
    resetN = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0, 0, 100, 200);
    #12;
    check("reset_state", 1'b0, 4'b0000, 8'd0);
    @(posedge clk);
    #1 resetN = 1'b1;

    tbl.push_back(v(0,1,1,110,231,100,200, 0,4'b0000,8'd0));
    tbl.push_back(v(0,0,0,  0,  0,100,200, 0,4'b0000,8'd0));
    tbl.push_back(v(0,0,0,  0,  0,100,200, 0,4'b0000,8'd0));
    tbl.push_back(v(1,0,0,  0,  0,100,200, 1,4'b0001,8'd1));
    tbl.push_back(v(0,0,0,  0,  0,100,200, 0,4'b0001,8'd1));
    tbl.push_back(v(0,1,1,100,200,100,200, 0,4'b0001,8'd1));
    tbl.push_back(v(0,1,1,131,215,100,200, 0,4'b0001,8'd1));
    tbl.push_back(v(0,0,0,  0,  0,100,200, 0,4'b0001,8'd1));
    tbl.push_back(v(1,0,0,  0,  0,100,200, 1,4'b1110,8'd2));
    tbl.push_back(v(0,0,0,  0,  0,100,200, 0,4'b1110,8'd2));
    tbl.push_back(v(0,1,0,100,200,100,200, 0,4'b1110,8'd2));
    tbl.push_back(v(0,0,1,131,231,100,200, 0,4'b1110,8'd2));
    tbl.push_back(v(1,0,0,  0,  0,100,200, 0,4'b0000,8'd2));
    tbl.push_back(v(0,0,0,  0,  0,100,200, 0,4'b0000,8'd2));
    tbl.push_back(v(0,1,1,  0,210,-10,200, 0,4'b0000,8'd2));
    tbl.push_back(v(0,0,0,  0,  0,100,200, 0,4'b0000,8'd2));
    tbl.push_back(v(1,0,0,  0,  0,100,200, 1,4'b0000,8'd3));
    tbl.push_back(v(0,0,0,  0,  0,100,200, 0,4'b0000,8'd3));
    tbl.push_back(v(0,1,1,110,231,100,200, 0,4'b0000,8'd3));
    tbl.push_back(v(1,0,0,  0,  0,100,200, 0,4'b0000,8'd3));
    tbl.push_back(v(0,0,0,  0,  0,100,200, 0,4'b0000,8'd3));
    tbl.push_back(v(1,0,0,  0,  0,100,200, 1,4'b0001,8'd4));
    tbl.push_back(v(0,0,0,  0,  0,100,200, 0,4'b0001,8'd4));
    tbl.push_back(v(0,1,1,100,200,100,200, 0,4'b0001,8'd4));
    tbl.push_back(v(0,1,1,131,231,100,200, 0,4'b0001,8'd4));
    tbl.push_back(v(1,0,0,  0,  0,100,200, 1,4'b1100,8'd5));
    tbl.push_back(v(1,0,0,  0,  0,100,200, 0,4'b1100,8'd5));
    tbl.push_back(v(0,0,0,  0,  0,100,200, 1,4'b0011,8'd6));
    tbl.push_back(v(0,0,0,  0,  0,100,200, 0,4'b0011,8'd6));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].sof, tbl[i].sm, tbl[i].br, tbl[i].px, tbl[i].py, tbl[i].tlx, tbl[i].tly);
      check($sformatf("table[%0d]", i), tbl[i].ec, tbl[i].eh, tbl[i].en);
    end

    begin
      int cnt;
      cnt = 6;
      for (int f = 0; f < 256; f++) begin
        step(1'b0, 1'b1, 1'b1, 110, 231, 100, 200);
        step(1'b0, 1'b0, 1'b0, 0, 0, 100, 200);
        step(1'b1, 1'b0, 1'b0, 0, 0, 100, 200);
        cnt = (cnt < 255) ? cnt + 1 : 255;
        check("saturate_frame", 1'b1, 4'b0001, 8'(cnt));
        step(1'b0, 1'b0, 1'b0, 0, 0, 100, 200);
      end
      check("saturate_final", 1'b0, 4'b0001, 8'd255);
    end

    step(1'b0, 1'b1, 1'b1, 100, 200, 100, 200);
    step(1'b0, 1'b0, 1'b0, 0, 0, 100, 200);
    #2 resetN = 1'b0;
    #1 check("async_reset", 1'b0, 4'b0000, 8'd0);
    @(posedge clk);
    #1 resetN = 1'b1;
    step(1'b0, 1'b0, 1'b0, 0, 0, 100, 200);
    step(1'b1, 1'b0, 1'b0, 0, 0, 100, 200);
    check("post_reset_sof", 1'b0, 4'b0000, 8'd0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 100, 200);
    check("post_reset_idle", 1'b0, 4'b0000, 8'd0);

    resetN = 1'b0;
    @(posedge clk);
    #1 resetN = 1'b1;
    m_coll = 1'b0; m_pend = 1'b0; m_code = 4'b0000; m_cnt = 0; cyc = 0;
    evq.delete();
    for (int n = 0; n < 3000; n++) begin
      int tlx, tly, px, py;
      logic sof, sm, br;
      tlx = int'($urandom_range(0, 1040)) - 40;
      tly = int'($urandom_range(0, 1040)) - 40;
      px  = tlx + int'($urandom_range(0, 44)) - 6;
      py  = tly + int'($urandom_range(0, 44)) - 6;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      sm  = ($urandom_range(0, 1) == 0);
      br  = ($urandom_range(0, 2) != 0);
      sof = ($urandom_range(0, 11) == 0) || (m_coll && $urandom_range(0, 3) == 0);
      cyc++;
      step(sof, sm, br, px, py, tlx, tly);
      model_edge(sof, sm & br, px - tlx, py - tly);
      check("random", m_coll, m_code, 8'(m_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
